fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined core. It owns the PC register, forms PC+4, and drives the instruction-memory request. It produces the IF/ID pipeline register (instruction, PC+4, valid) that the decode stage consumes. It handles decode-stage stalls, branch/jump redirects with squash, instruction-memory wait states, and misaligned redirect targets.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000000, encoding placed in id_instr whenever id_valid=0; control decodes it as no-op.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall_id  in  1  hazard unit: hold IF/ID contents and PC.
redirect_valid  in  1  taken branch/jump resolved downstream this cycle.
redirect_pc  in  32  target PC for redirect.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address, equal to pc_q.
imem_data  in  32  instruction word, valid when imem_ready=1.
imem_ready  in  1  imem_data valid for the current imem_addr in this cycle.
id_instr  out  32  IF/ID instruction.
id_pcplus4  out  32  IF/ID PC+4 of that instruction.
id_valid  out  1  IF/ID holds a real instruction.
misalign_err  out  1  sticky: a redirect target had nonzero bits [1:0].

Behaviour:
- Reset (async, any time, including mid-wait): pc_q=RESET_PC, state=BOOT, id_valid=0, id_instr=NOP_INSTR, id_pcplus4=0, misalign_err=0, imem_req=0.
- imem_addr=pc_q at all times (combinational). imem_req=1 only in state FETCH.
- FSM:
  - BOOT: lasts exactly one cycle after reset deasserts, with no request, then goes to FETCH.
  - FETCH: the only other state. No return to BOOT except through reset.
- Per-cycle priority in FETCH, highest first:
  1. redirect_valid=1:
     - pc_q <= {redirect_pc[31:2],2'b00}.
     - IF/ID squashed: id_valid<=0, id_instr<=NOP_INSTR. This overrides stall_id.
     - imem_data this cycle is discarded.
     - If redirect_pc[1:0]!=0, misalign_err<=1. It stays set until reset.
  2. stall_id=1: pc_q and all IF/ID outputs hold. imem_data is discarded even if imem_ready=1, and the same address is re-fetched next cycle.
  3. imem_ready=1: id_instr<=imem_data, id_pcplus4<=pc_q+4, id_valid<=1, pc_q<=pc_q+4.
  4. imem_ready=0: bubble inserted. id_valid<=0, id_instr<=NOP_INSTR, pc_q holds.
- redirect_valid in BOOT: accepted (pc_q updated, flag rule applies). The BOOT->FETCH transition still occurs.
- Latency: an instruction appears in IF/ID one clock after the edge where imem_ready=1 and no stall or redirect. Steady-state throughput is 1 instr/cycle.
- Arithmetic: 32-bit unsigned, PC+4 wraps 32'hFFFFFFFC -> 32'h00000000 with no flag.
- id_pcplus4 is not updated on bubble or squash; only id_valid/id_instr change.

Decomposition:
- Shared package: RESET_PC and NOP_INSTR defaults, the state encoding (BOOT, FETCH), and the 32-bit word width constant.
- One sub-module, if_id_reg: IF/ID register with load-enable and synchronous squash. Squash takes priority over hold. Async reset to the NOP/invalid values.
- PC register, PC+4 adder and FSM stay in fetch_stage.

Test Plan:
- Reset then release, imem_ready=1 constantly, imem_data=address-tag -> cycle 1 imem_req=0. Then addresses 0,4,8 in order. id_valid first rises with id_instr=tag(0), id_pcplus4=4.
- stall_id high 3 cycles while streaming -> IF/ID and pc_q frozen. After release, the fetch resumes at the same address with no instruction lost or duplicated.
- imem_ready low 2 cycles at PC=8 -> two bubbles (id_valid=0, id_instr=NOP_INSTR). Then id_instr=tag(8), id_pcplus4=12.
- redirect_valid=1, redirect_pc=0x100, together with stall_id=1 -> next cycle id_valid=0, imem_addr=0x100. The next instruction has id_pcplus4=0x104.
- Redirect to 0x203 -> imem_addr=0x200, misalign_err=1. It stays 1 through later redirects and clears only on rst.
- Redirect to 0xFFFFFFFC, fetch once -> id_pcplus4=0x00000000, imem_addr=0. Assert rst mid-stream -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, reset
// defaults and the fetch FSM encoding.
package fetch_stage_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_STEP       = 32'd4;

    typedef enum logic {
        ST_BOOT  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Squash wins over load and over hold; on squash
// only the valid bit and instruction change, PC+4 keeps its last value.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              squash_i,
    input  logic [WORD_W-1:0] instr_i,
    input  logic [WORD_W-1:0] pcplus4_i,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] pcplus4_o,
    output logic              valid_o
);

    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pcplus4_q, pcplus4_d;
    logic              valid_q, valid_d;

    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (squash_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d   = instr_i;
            pcplus4_d = pcplus4_i;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder, fetch FSM and the
// instruction-memory request feeding the IF/ID register.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_BOOT  | single idle cycle after reset release, no imem request
//   ST_FETCH | fetching at pc_q every cycle; left only through reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_id,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              imem_ready,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pcplus4,
    output logic              id_valid,
    output logic              misalign_err
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pcplus4;
    logic              misalign_q, misalign_d;
    logic              load, squash;

    assign pcplus4 = pc_q + PC_STEP;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load       = 1'b0;
        squash     = 1'b0;
        misalign_d = misalign_q | (redirect_valid & (|redirect_pc[1:0]));

        unique case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase

        // A redirect is honoured even in BOOT so a target issued right after
        // reset is not lost.
        if (redirect_valid) begin
            pc_d   = {redirect_pc[WORD_W-1:2], 2'b00};
            squash = 1'b1;
        end else if (state_q == ST_FETCH && !stall_id) begin
            if (imem_ready) begin
                load = 1'b1;
                pc_d = pcplus4;
            end else begin
                squash = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .squash_i  (squash),
        .instr_i   (imem_data),
        .pcplus4_i (pcplus4),
        .instr_o   (id_instr),
        .pcplus4_o (id_pcplus4),
        .valid_o   (id_valid)
    );

    assign imem_req     = (state_q == ST_FETCH);
    assign imem_addr    = pc_q;
    assign misalign_err = misalign_q;

endmodule
